// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//
// Run controller for the pipelined RV32 CPU. It holds the CPU in reset for a
// fixed number of cycles, then lets it run while it counts RUN cycles and
// retired instructions. A run ends on one of three conditions: a store to the
// tohost address, the cycle limit, or (optionally) a retirement stall. Once a
// run has ended, the CPU is frozen in reset until `restart` or `reset`.
//
// Optional feature macro: RUN_CTRL_STALL_CHECK_EN
//   When defined, a run that retires nothing for STALL_LIMIT consecutive RUN
//   cycles ends with stall_fail=1. When undefined, stall_fail is tied to 0.
//
// Ports
//   clk           in   single clock, rising edge
//   reset         in   synchronous, active-high; has priority over restart
//   restart       in   one-cycle pulse; begins a new run from HOLD
//   dmem_we       in   snooped data-memory write enable
//   dmem_addr     in   snooped data-memory byte address (XLEN)
//   dmem_wdata    in   snooped data-memory write data (XLEN)
//   retire_valid  in   one instruction retired this cycle
//   cpu_reset     out  active-high reset to the CPU
//   running       out  high in RUN
//   done          out  high in DONE
//   pass          out  run ended by a tohost store of value 1
//   timeout       out  run ended by the cycle limit
//   stall_fail    out  run ended by a retirement stall
//   exit_code     out  dmem_wdata[XLEN-1:1] of the terminating tohost store
//   cycle_count   out  RUN cycles elapsed (wraps)
//   retire_count  out  instructions retired during RUN (wraps)

module cpu_run_controller #(
  parameter int               RESET_CYCLES   = 2,
  parameter int               TIMEOUT_CYCLES = 100,
  parameter int               XLEN           = 32,
  parameter logic [XLEN-1:0]  TOHOST_ADDR    = 32'h0000_0100,
  parameter int               CNT_W          = 32,
  parameter int               STALL_LIMIT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              dmem_we,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic              retire_valid,
  output logic              cpu_reset,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              stall_fail,
  output logic [XLEN-2:0]   exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The hold counter only has to reach RESET_CYCLES-1.
  localparam int               HOLD_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Reject parameter values that would make the sequence meaningless.
  if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1 || STALL_LIMIT < 1) begin : g_param_check
    $error("cpu_run_controller: RESET_CYCLES, TIMEOUT_CYCLES and STALL_LIMIT must be >= 1");
  end

  state_t             state_r;
  state_t             state_s;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [HOLD_W-1:0]  hold_cnt_s;

  logic               cpu_reset_r;
  logic               running_r;
  logic               done_r;
  logic               pass_r;
  logic               pass_s;
  logic               timeout_r;
  logic               timeout_s;
  logic [XLEN-2:0]    exit_code_r;
  logic [XLEN-2:0]    exit_code_s;
  logic [CNT_W-1:0]   cycle_count_r;
  logic [CNT_W-1:0]   cycle_count_s;
  logic [CNT_W-1:0]   retire_count_r;
  logic [CNT_W-1:0]   retire_count_s;

  logic               tohost_hit_s;
  logic               timeout_hit_s;
  logic               stall_hit_s;
  logic               end_hit_s;

  // The timeout fires on the cycle whose own increment reaches the limit.
  assign tohost_hit_s  = dmem_we && (dmem_addr == TOHOST_ADDR);
  assign timeout_hit_s = (cycle_count_r == TIMEOUT_LAST);
  assign end_hit_s     = tohost_hit_s || timeout_hit_s || stall_hit_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; restart wins over any end condition in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HOLD: begin
        if (restart) begin
          state_s = ST_HOLD;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_RUN: begin
        if (restart) begin
          state_s = ST_HOLD;
        end else if (end_hit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (restart) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_HOLD;
      end
    endcase
  end

  // Next values of counters and result flags; registered below.
  always_comb begin
    hold_cnt_s     = hold_cnt_r;
    pass_s         = pass_r;
    timeout_s      = timeout_r;
    exit_code_s    = exit_code_r;
    cycle_count_s  = cycle_count_r;
    retire_count_s = retire_count_r;
    if (restart) begin
      hold_cnt_s     = {HOLD_W{1'b0}};
      pass_s         = 1'b0;
      timeout_s      = 1'b0;
      exit_code_s    = {(XLEN-1){1'b0}};
      cycle_count_s  = {CNT_W{1'b0}};
      retire_count_s = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            hold_cnt_s = {HOLD_W{1'b0}};
          end else begin
            hold_cnt_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          // The terminating cycle and any retire in it are still counted.
          cycle_count_s = cycle_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (retire_valid) begin
            retire_count_s = retire_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            retire_count_s = retire_count_r;
          end
          if (tohost_hit_s) begin
            pass_s      = (dmem_wdata == {{(XLEN-1){1'b0}}, 1'b1});
            exit_code_s = dmem_wdata[XLEN-1:1];
          end else if (timeout_hit_s) begin
            timeout_s = 1'b1;
          end else begin
            timeout_s = timeout_r;
          end
        end
        ST_DONE: begin
          hold_cnt_s = hold_cnt_r;
        end
        default: begin
          hold_cnt_s = {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  // Output and counter registers; the CPU-facing strobes follow the next state
  // so that they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r     <= {HOLD_W{1'b0}};
      cpu_reset_r    <= 1'b1;
      running_r      <= 1'b0;
      done_r         <= 1'b0;
      pass_r         <= 1'b0;
      timeout_r      <= 1'b0;
      exit_code_r    <= {(XLEN-1){1'b0}};
      cycle_count_r  <= {CNT_W{1'b0}};
      retire_count_r <= {CNT_W{1'b0}};
    end else begin
      hold_cnt_r     <= hold_cnt_s;
      cpu_reset_r    <= (state_s != ST_RUN);
      running_r      <= (state_s == ST_RUN);
      done_r         <= (state_s == ST_DONE);
      pass_r         <= pass_s;
      timeout_r      <= timeout_s;
      exit_code_r    <= exit_code_s;
      cycle_count_r  <= cycle_count_s;
      retire_count_r <= retire_count_s;
    end
  end

`ifdef RUN_CTRL_STALL_CHECK_EN
  localparam int                 STALL_W    = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  logic [STALL_W-1:0] stall_cnt_r;
  logic [STALL_W-1:0] stall_cnt_s;
  logic               stall_fail_r;
  logic               stall_fail_s;

  // A stall ends the run when this cycle is the STALL_LIMIT-th without a retire.
  assign stall_hit_s = !retire_valid && (stall_cnt_r == STALL_LAST);

  // Stall counter and flag next values; lower-priority than tohost and timeout.
  always_comb begin
    stall_cnt_s  = stall_cnt_r;
    stall_fail_s = stall_fail_r;
    if (restart) begin
      stall_cnt_s  = {STALL_W{1'b0}};
      stall_fail_s = 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          stall_cnt_s = {STALL_W{1'b0}};
        end
        ST_RUN: begin
          if (retire_valid) begin
            stall_cnt_s = {STALL_W{1'b0}};
          end else begin
            stall_cnt_s = stall_cnt_r + {{(STALL_W-1){1'b0}}, 1'b1};
          end
          if (stall_hit_s && !tohost_hit_s && !timeout_hit_s) begin
            stall_fail_s = 1'b1;
          end else begin
            stall_fail_s = stall_fail_r;
          end
        end
        ST_DONE: begin
          stall_cnt_s = stall_cnt_r;
        end
        default: begin
          stall_cnt_s = {STALL_W{1'b0}};
        end
      endcase
    end
  end

  // Stall counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r  <= {STALL_W{1'b0}};
      stall_fail_r <= 1'b0;
    end else begin
      stall_cnt_r  <= stall_cnt_s;
      stall_fail_r <= stall_fail_s;
    end
  end

  assign stall_fail = stall_fail_r;
`else
  assign stall_hit_s = 1'b0;
  assign stall_fail  = 1'b0;
`endif

  assign cpu_reset    = cpu_reset_r;
  assign running      = running_r;
  assign done         = done_r;
  assign pass         = pass_r;
  assign timeout      = timeout_r;
  assign exit_code    = exit_code_r;
  assign cycle_count  = cycle_count_r;
  assign retire_count = retire_count_r;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller (default parameters). Stimulus
// pushes an expected event (reset, run start, run end) into a queue; the
// monitor pops one entry whenever the DUT presents the matching event.
module tb_cpu_run_controller;

  localparam int EV_RESET = 0;
  localparam int EV_START = 1;
  localparam int EV_DONE  = 2;

  logic        clk;
  logic        reset;
  logic        restart;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        retire_valid;
  logic        cpu_reset;
  logic        running;
  logic        done;
  logic        pass;
  logic        timeout;
  logic        stall_fail;
  logic [30:0] exit_code;
  logic [31:0] cycle_count;
  logic [31:0] retire_count;

  typedef struct {
    int          kind;
    logic        pass;
    logic        timeout;
    logic        stall;
    logic [30:0] exit_code;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  cpu_run_controller dut (
    .clk          (clk),
    .reset        (reset),
    .restart      (restart),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .retire_valid (retire_valid),
    .cpu_reset    (cpu_reset),
    .running      (running),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .stall_fail   (stall_fail),
    .exit_code    (exit_code),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic p, input logic t, input logic s,
                         input logic [30:0] ex, input logic [31:0] cy, input logic [31:0] re);
    exp_t e;
    e.kind = kind; e.pass = p; e.timeout = t; e.stall = s;
    e.exit_code = ex; e.cyc = cy; e.ret = re;
    q.push_back(e);
  endtask

  task automatic compare_ev(input int kind, input int hold_edges);
    exp_t e;
    if (q.size() == 0) begin
      vectors++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d, expected none at %0t", kind, $time);
    end else begin
      e = q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (kind == EV_START) begin
        chk("hold_edges", 64'(hold_edges), 64'(2));
      end
      chk("cpu_reset", 64'(cpu_reset), (kind == EV_START) ? 64'(0) : 64'(1));
      chk("running", 64'(running), (kind == EV_START) ? 64'(1) : 64'(0));
      chk("done", 64'(done), (kind == EV_DONE) ? 64'(1) : 64'(0));
      chk("pass", 64'(pass), 64'(e.pass));
      chk("timeout", 64'(timeout), 64'(e.timeout));
      chk("stall_fail", 64'(stall_fail), 64'(e.stall));
      chk("exit_code", 64'(exit_code), 64'(e.exit_code));
      chk("cycle_count", 64'(cycle_count), 64'(e.cyc));
      chk("retire_count", 64'(retire_count), 64'(e.ret));
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic rs, rr, prev_run, prev_done;
    int   hold_seen;
    prev_run = 1'b0; prev_done = 1'b0; hold_seen = 0;
    forever begin
      @(posedge clk);
      rs = reset;
      rr = restart;
      #1;
      if (rs) begin
        compare_ev(EV_RESET, 0);
        hold_seen = 0;
      end else begin
        if (running && !prev_run) begin
          compare_ev(EV_START, hold_seen + 1);
        end else if (done && !prev_done) begin
          compare_ev(EV_DONE, 0);
        end
        if (rr) hold_seen = 0;
        else if (cpu_reset && !running && !done) hold_seen++;
      end
      prev_run = running;
      prev_done = done;
    end
  end

  task automatic clear_inputs();
    dmem_we = 1'b0; dmem_addr = 32'h0000_0000; dmem_wdata = 32'h0000_0000;
    retire_valid = 1'b0; restart = 1'b0;
  endtask

  task automatic wait_running();
    int i;
    i = 0;
    while (!running && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (!running) begin
      vectors++;
      errors++;
      $display("FAIL wait_running: got running=0, expected 1 within 20 cycles");
    end
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    push_ev(EV_START, 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'd0);
    @(negedge clk);
    restart = 1'b0;
    wait_running();
  endtask

  // Drive RUN cycles 1.. until done. Non-store cycles present a tohost
  // address with dmem_we=0 so that a load-like access must be ignored.
  task automatic do_run(input int s1c, input logic [31:0] s1a, input logic [31:0] s1d,
                        input int s2c, input logic [31:0] s2a, input logic [31:0] s2d,
                        input int ret_upto);
    int c;
    c = 1;
    while (!done && c <= 160) begin
      retire_valid = (c <= ret_upto);
      if (c == s1c) begin
        dmem_we = 1'b1; dmem_addr = s1a; dmem_wdata = s1d;
      end else if (c == s2c) begin
        dmem_we = 1'b1; dmem_addr = s2a; dmem_wdata = s2d;
      end else begin
        dmem_we = 1'b0; dmem_addr = 32'h0000_0100; dmem_wdata = 32'h0000_0001;
      end
      @(negedge clk);
      c++;
    end
    clear_inputs();
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL run_bound: got done=0, expected 1 within 160 cycles");
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    push_ev(EV_RESET, 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'd0);
    push_ev(EV_RESET, 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_ev(EV_START, 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'd0);
    wait_running();

    // Pass: store 1 on cycle 40 after 25 retires.
    push_ev(EV_DONE, 1'b1, 1'b0, 1'b0, 31'h0, 32'd40, 32'd25);
    do_run(40, 32'h0000_0100, 32'h0000_0001, 0, 32'h0, 32'h0, 25);

    // Fail code: store to 0x104 ignored, store 7 to tohost gives exit 3.
    restart_pulse();
    push_ev(EV_DONE, 1'b0, 1'b0, 1'b0, 31'd3, 32'd20, 32'd20);
    do_run(5, 32'h0000_0104, 32'h0000_0007, 20, 32'h0000_0100, 32'h0000_0007, 200);

    // Timeout at the cycle limit with retires every cycle.
    restart_pulse();
    push_ev(EV_DONE, 1'b0, 1'b1, 1'b0, 31'h0, 32'd100, 32'd100);
    do_run(0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 200);

    // Tohost on the timeout cycle wins over the timeout.
    restart_pulse();
    push_ev(EV_DONE, 1'b1, 1'b0, 1'b0, 31'h0, 32'd100, 32'd100);
    do_run(100, 32'h0000_0100, 32'h0000_0001, 0, 32'h0, 32'h0, 200);

    // Retires stop after cycle 10.
    restart_pulse();
`ifdef RUN_CTRL_STALL_CHECK_EN
    push_ev(EV_DONE, 1'b0, 1'b0, 1'b1, 31'h0, 32'd26, 32'd10);
`else
    push_ev(EV_DONE, 1'b0, 1'b1, 1'b0, 31'h0, 32'd100, 32'd10);
`endif
    do_run(0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 10);

    // All-ones store on the first RUN cycle, retire in the same cycle.
    restart_pulse();
    push_ev(EV_DONE, 1'b0, 1'b0, 1'b0, 31'h7FFF_FFFF, 32'd1, 32'd1);
    do_run(1, 32'h0000_0100, 32'hFFFF_FFFF, 0, 32'h0, 32'h0, 1);

    // Restart in the same cycle as a tohost store: no DONE, a new run starts.
    restart_pulse();
    repeat (4) begin
      retire_valid = 1'b1;
      @(negedge clk);
    end
    dmem_we = 1'b1; dmem_addr = 32'h0000_0100; dmem_wdata = 32'h0000_0001;
    retire_valid = 1'b1; restart = 1'b1;
    push_ev(EV_START, 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'd0);
    @(negedge clk);
    clear_inputs();
    wait_running();
    push_ev(EV_DONE, 1'b1, 1'b0, 1'b0, 31'h0, 32'd2, 32'd2);
    do_run(2, 32'h0000_0100, 32'h0000_0001, 0, 32'h0, 32'h0, 200);

    // Reset mid-RUN returns everything to reset values, then a clean run.
    restart_pulse();
    repeat (30) begin
      retire_valid = 1'b1;
      @(negedge clk);
    end
    clear_inputs();
    reset = 1'b1;
    push_ev(EV_RESET, 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    push_ev(EV_START, 1'b0, 1'b0, 1'b0, 31'h0, 32'd0, 32'd0);
    wait_running();
    push_ev(EV_DONE, 1'b1, 1'b0, 1'b0, 31'h0, 32'd3, 32'd3);
    do_run(3, 32'h0000_0100, 32'h0000_0001, 0, 32'h0, 32'h0, 200);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Synthesizable run controller for the pipelined RV32 CPU. It generalises the fixed reset/run/finish sequence used in simulation into one parametrised block. It drives the CPU's reset, counts cycles and retired instructions, and ends a run on a tohost store, a timeout or (optionally) a retirement stall. It sits between the top-level clock/reset and `pipeline_cpu_top`, and snoops the data-memory write port and the writeback retire strobe.

## Interface
- `RESET_CYCLES`, default 2: cycles `cpu_reset` is held after controller reset or restart; must be ≥1.
- `TIMEOUT_CYCLES`, default 100: maximum RUN cycles before a timeout end; must be ≥1.
- `XLEN`, default 32: data/address width.
- `TOHOST_ADDR`, default 32'h0000_0100: byte address whose store ends the run.
- `CNT_W`, default 32: width of the cycle and retire counters.
- `STALL_LIMIT`, default 16: consecutive non-retiring RUN cycles that count as a hang. Only used with `RUN_CTRL_STALL_CHECK_EN`.
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: synchronous, active-high.
- `restart` input, 1: one-cycle pulse; starts a new run.
- `dmem_we` input, 1: data-memory write enable, snooped.
- `dmem_addr` input, XLEN: data-memory byte address.
- `dmem_wdata` input, XLEN: data-memory write data.
- `retire_valid` input, 1: one instruction retired this cycle.
- `cpu_reset` output, 1: reset to the CPU, active-high.
- `running` output, 1: high in RUN.
- `done` output, 1: high in DONE.
- `pass` output, 1: run ended by tohost store of value 1.
- `timeout` output, 1: run ended by cycle limit.
- `stall_fail` output, 1: run ended by retirement stall.
- `exit_code` output, XLEN-1: `dmem_wdata[XLEN-1:1]` of the terminating tohost store.
- `cycle_count` output, CNT_W: RUN cycles elapsed.
- `retire_count` output, CNT_W: instructions retired during RUN.

Clock is `clk`. Reset is `reset`, synchronous and active-high.

## Operation
- FSM states: HOLD, RUN, DONE. All outputs are registered.
- **Reset:** state=HOLD, hold counter=0. Output values: `cpu_reset`=1, `running`=0, `done`=0, `pass`=0, `timeout`=0, `stall_fail`=0, `exit_code`=0, `cycle_count`=0, `retire_count`=0.
- **HOLD:** `cpu_reset`=1. The hold counter increments each cycle. After RESET_CYCLES cycles the FSM moves to RUN, and `cpu_reset`=0 from the same edge.
- **RUN:**
  - `cycle_count` increments every cycle.
  - `retire_count` increments when `retire_valid`=1.
  - End conditions are checked with priority tohost > timeout > stall.
- **Tohost:** `dmem_we`=1 and `dmem_addr`==TOHOST_ADDR moves the FSM to DONE.
  - `pass` = (`dmem_wdata`==1).
  - `exit_code` = `dmem_wdata[XLEN-1:1]`.
- **Timeout:** if `cycle_count`==TIMEOUT_CYCLES-1 with no tohost store, the FSM moves to DONE with `timeout`=1.
- **DONE:**
  - `cpu_reset`=1, which freezes the CPU.
  - Counters and result flags hold their values.
  - Snoop inputs are ignored.
- **Restart:** `restart`=1 in any state moves the FSM to HOLD.
  - Counters, hold counter and result flags are cleared.
  - Restart overrides any end condition in the same cycle.
- **Overflow:** counters wrap modulo 2^CNT_W. There is no saturation.
- Stores to other addresses are ignored.
- Loads are never observed.

## Timing
- From the first edge with `reset`=0, `cpu_reset` stays high for exactly RESET_CYCLES edges. `running` rises on the same edge that `cpu_reset` falls.
- Latency is 1 cycle: an end condition sampled at edge N gives `done`=1, `running`=0 and `cpu_reset`=1 after edge N.
- The terminating cycle is counted. A tohost store on the k-th RUN cycle leaves `cycle_count`=k. A retire in that same cycle is counted.
- Exactly one of `pass`, `timeout`, `stall_fail` can be set, or none when the store value ≠1 (fail with `exit_code`).
- `reset` mid-RUN behaves exactly like power-on reset. `reset` has priority over `restart`.

## Configuration
- Macro: `RUN_CTRL_STALL_CHECK_EN`.
- **Defined:**
  - A stall counter counts consecutive RUN cycles with `retire_valid`=0. It clears on each retire and in HOLD.
  - When it reaches STALL_LIMIT with no tohost store or timeout that cycle, the FSM moves to DONE with `stall_fail`=1.
- **Undefined:** no stall logic. `stall_fail` is tied to 0 and STALL_LIMIT is unused.

## Test plan
- **Reset release:** reset for 2 cycles, then release with RESET_CYCLES=2 → `cpu_reset` high for exactly 2 edges, then `running`=1, `cycle_count` starts at 1.
- **Pass:** store 32'h1 to 32'h100 on RUN cycle 40 with 25 retires before it → next cycle `done`=1, `pass`=1, `exit_code`=0, `cycle_count`=40, `retire_count`=25.
- **Fail code:** store 32'h7 to 32'h100 → `pass`=0, `exit_code`=3. A store of 32'h7 to 32'h104 is ignored and the run continues.
- **Timeout and priority:** with no tohost store and TIMEOUT_CYCLES=100 → `timeout`=1 with `cycle_count`=100. A tohost store on cycle 100 instead gives `timeout`=0.
- **Stall** (macro defined, STALL_LIMIT=16): retires stop after cycle 10 → `stall_fail`=1 with `cycle_count`=26. With the macro undefined, the same stimulus ends in timeout.
- **Restart and reset mid-run:** `restart` in DONE → all results clear and HOLD lasts 2 cycles. `reset` asserted mid-RUN → all outputs return to their reset values on the next edge.
